// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Instruction fetch stage. Owns the fetch PC and issues in-order word reads
//   to instruction memory. Returned words are buffered together with their PCs
//   and offered to decode over a valid/ready handshake. A redirect flushes the
//   buffer and arranges for the responses still in flight to be dropped. Once
//   decode reports HALT, no new reads are issued.
//
//   Each buffer entry moves EMPTY -> PENDING -> READY -> EMPTY. Three wrapping
//   pointers select the entries: alloc (next issue), fill (next response) and
//   read (head toward decode).
//
// Parameters
//   RESET_ADDR  PC after reset (4-byte aligned)
//   DEPTH       buffer entries, power of two, >= 2
//
// Ports
//   i_clk, i_rst              clock, asynchronous active-high reset
//   o_imem_req/o_imem_addr    read request toward instruction memory
//   i_imem_ready              memory accepts the request this cycle
//   i_imem_rvalid/rdata       in-order read response
//   o_instr_valid/o_instr/o_pc  head entry toward decode
//   i_instr_ready             decode consumes the head entry
//   i_redirect/i_redirect_pc  load a new PC and flush
//   i_halt                    decode has seen HALT
//   o_halted                  sticky: halt seen and nothing in flight
//   o_fetch_count/o_flush_count  performance counters
//
// Configuration
//   IFU_PERF_CNT_EN  when defined, o_fetch_count counts consumed instructions
//                    and o_flush_count counts accepted redirects (both wrap).
//                    When undefined both outputs are tied to zero.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_instr_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_halt,
  output logic        o_halted,
  output logic [31:0] o_fetch_count,
  output logic [31:0] o_flush_count
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  // Reads dropped after a redirect are bounded by the memory pipeline depth,
  // not by DEPTH, since repeated redirects can stack them up.
  localparam int DISC_W = 16;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PENDING,
    ST_READY
  } entry_st_e;

  entry_st_e         st_q   [DEPTH];
  entry_st_e         st_d   [DEPTH];
  logic [31:0]       pc_q   [DEPTH];
  logic [31:0]       pc_d   [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [31:0]       data_d [DEPTH];
  logic [PTR_W-1:0]  alloc_q, alloc_d;
  logic [PTR_W-1:0]  fill_q, fill_d;
  logic [PTR_W-1:0]  read_q, read_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [DISC_W-1:0] discard_q, discard_d;
  logic              halt_seen_q, halt_seen_d;
  logic              halted_q, halted_d;

  logic             redirect_take;
  logic             halt_now;
  logic             issue;
  logic             resp_keep;
  logic             resp_drop;
  logic             consume;
  logic [CNT_W-1:0] pending_cnt;

  // Redirects stop mattering once the unit has halted.
  assign redirect_take = i_redirect && !halted_q;
  // A halt blocks issue in the very cycle it is reported.
  assign halt_now      = halt_seen_q || i_halt;

  assign o_imem_req    = !i_rst && !i_redirect && !halt_now && (st_q[alloc_q] == ST_EMPTY);
  assign o_imem_addr   = fetch_pc_q;
  assign issue         = o_imem_req && i_imem_ready;
  assign resp_drop     = i_imem_rvalid && (discard_q != '0);
  assign resp_keep     = i_imem_rvalid && (discard_q == '0);

  assign o_instr_valid = (st_q[read_q] == ST_READY);
  assign o_instr       = data_q[read_q];
  assign o_pc          = pc_q[read_q];
  assign o_halted      = halted_q;
  // A redirect wins over a handshake in the same cycle.
  assign consume       = o_instr_valid && i_instr_ready && !redirect_take;

  always_comb begin
    pending_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (st_q[i] == ST_PENDING) pending_cnt = pending_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    st_d        = st_q;
    pc_d        = pc_q;
    data_d      = data_q;
    alloc_d     = alloc_q;
    fill_d      = fill_q;
    read_d      = read_q;
    fetch_pc_d  = fetch_pc_q;
    discard_d   = discard_q;
    halt_seen_d = halt_seen_q || i_halt;
    halted_d    = halted_q || (halt_seen_q && (pending_cnt == '0) && (discard_q == '0));

    if (redirect_take) begin
      for (int i = 0; i < DEPTH; i++) st_d[i] = ST_EMPTY;
      alloc_d    = '0;
      fill_d     = '0;
      read_d     = '0;
      fetch_pc_d = i_redirect_pc & ~32'h3;
      // Every flushed PENDING read is still owed by memory, except the one
      // whose response lands right now; a dropped response this cycle also
      // retires one old discard. Both cases reduce to subtracting rvalid.
      discard_d  = discard_q + DISC_W'(pending_cnt) - DISC_W'(i_imem_rvalid);
    end else begin
      if (issue) begin
        st_d[alloc_q] = ST_PENDING;
        pc_d[alloc_q] = fetch_pc_q;
        alloc_d       = alloc_q + PTR_W'(1);
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end
      if (resp_drop) begin
        discard_d = discard_q - DISC_W'(1);
      end
      if (resp_keep) begin
        st_d[fill_q]   = ST_READY;
        data_d[fill_q] = i_imem_rdata;
        fill_d         = fill_q + PTR_W'(1);
      end
      if (consume) begin
        st_d[read_q] = ST_EMPTY;
        read_d       = read_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: the buffer arrays are reset too, so o_pc/o_instr show
      // RESET_ADDR/0 while reset is held instead of stale contents.
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]   <= ST_EMPTY;
        pc_q[i]   <= RESET_ADDR;
        data_q[i] <= '0;
      end
      alloc_q     <= '0;
      fill_q      <= '0;
      read_q      <= '0;
      fetch_pc_q  <= RESET_ADDR;
      discard_q   <= '0;
      halt_seen_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // computed for this cycle, independent of statement order.
      st_q        <= st_d;
      pc_q        <= pc_d;
      data_q      <= data_d;
      alloc_q     <= alloc_d;
      fill_q      <= fill_d;
      read_q      <= read_d;
      fetch_pc_q  <= fetch_pc_d;
      discard_q   <= discard_d;
      halt_seen_q <= halt_seen_d;
      halted_q    <= halted_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + (consume ? 32'd1 : 32'd0);
    flush_cnt_d = flush_cnt_q + (redirect_take ? 32'd1 : 32'd0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_fetch_count = fetch_cnt_q;
  assign o_flush_count = flush_cnt_q;
`else
  assign o_fetch_count = 32'h0;
  assign o_flush_count = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  // Four entries so a one-cycle memory can sustain one instruction per cycle.
  localparam int          DEPTH      = 4;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        i_instr_ready = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        i_halt = 1'b0;
  logic        o_halted;
  logic [31:0] o_fetch_count;
  logic [31:0] o_flush_count;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_ADDR(RESET_ADDR), .DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ready  (i_imem_ready),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_instr_valid (o_instr_valid),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .i_instr_ready (i_instr_ready),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_halt        (i_halt),
    .o_halted      (o_halted),
    .o_fetch_count (o_fetch_count),
    .o_flush_count (o_flush_count)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model: in-order, per-request latency ----------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  int          cyc       = 0;
  int          lat_min   = 1;
  int          lat_max   = 1;
  int          ready_pct = 100;
  logic [31:0] salt      = '0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ salt;
  endfunction

  // ---------------- reference model: program-order stream ----------------
  // Delivered PCs form a sequence starting at RESET_ADDR, stepping by 4 and
  // restarting at every accepted redirect target; the word is the memory
  // contents at that PC. Halted means halt seen and nothing owed by memory.
  logic [31:0] exp_pc;
  logic [31:0] exp_fetch;
  logic [31:0] exp_flush;
  bit          halt_seen_m;
  bit          halted_m;
  int          delivered = 0;
  int          max_out   = 0;

  // Values observed during the last step.
  logic        obs_req, obs_valid, hs_fired;
  logic [31:0] obs_addr, obs_pc, obs_instr;

  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc, input logic halt);
    int out_before;
    bit redir_take;
    bit hs;
    @(negedge clk);
    i_instr_ready = rdy;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    i_halt        = halt;
    i_imem_ready  = ($urandom_range(99) < ready_pct);
    out_before    = memq.size();
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = mem_data(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = $urandom;
    end
    #1;
    obs_req    = o_imem_req;
    obs_addr   = o_imem_addr;
    obs_valid  = o_instr_valid;
    obs_pc     = o_pc;
    obs_instr  = o_instr;
    hs_fired   = 1'b0;
    redir_take = redir && !halted_m;
    hs         = halt_seen_m || halt;

    check("halted", o_halted, halted_m);
    if (redir || hs) check("req_blocked", o_imem_req, 1'b0);
    if (o_imem_req) check("addr_align", {30'b0, o_imem_addr[1:0]}, 32'h0);
`ifdef IFU_PERF_CNT_EN
    check("fetch_count", o_fetch_count, exp_fetch);
    check("flush_count", o_flush_count, exp_flush);
`else
    check("fetch_count_off", o_fetch_count, 32'h0);
    check("flush_count_off", o_flush_count, 32'h0);
`endif

    if (o_imem_req && i_imem_ready)
      memq.push_back('{o_imem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
    if (memq.size() > max_out) max_out = memq.size();

    if (o_instr_valid && rdy && !redir_take) begin
      check("pc", o_pc, exp_pc);
      check("instr", o_instr, mem_data(exp_pc));
      exp_pc    = exp_pc + 32'd4;
      exp_fetch = exp_fetch + 32'd1;
      delivered++;
      hs_fired  = 1'b1;
    end
    if (redir_take) begin
      exp_pc    = rpc & ~32'h3;
      exp_flush = exp_flush + 32'd1;
    end
    halted_m    = halted_m || (halt_seen_m && out_before == 0);
    halt_seen_m = hs;
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst         = 1'b1;
    i_instr_ready = 1'b0;
    i_redirect    = 1'b0;
    i_halt        = 1'b0;
    i_imem_rvalid = 1'b0;
    i_imem_ready  = 1'b0;
    memq.delete();
    #1;
    check("rst_req", o_imem_req, 1'b0);
    check("rst_valid", o_instr_valid, 1'b0);
    check("rst_instr", o_instr, 32'h0);
    check("rst_pc", o_pc, RESET_ADDR);
    check("rst_halted", o_halted, 1'b0);
    check("rst_fetch_count", o_fetch_count, 32'h0);
    check("rst_flush_count", o_flush_count, 32'h0);
    exp_pc      = RESET_ADDR;
    exp_fetch   = '0;
    exp_flush   = '0;
    halt_seen_m = 1'b0;
    halted_m    = 1'b0;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
  endtask

  // Cycle-exact vectors from reset release: one-cycle memory, decode stalls
  // for seven cycles (buffer fills, issue stops, head pc 0 held) then drains.
  typedef struct {
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int d0;
    bit got;

    tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
    tbl[4]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
    tbl[5]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
    tbl[6]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
    tbl[7]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h00};
    tbl[8]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h04};
    tbl[9]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
    tbl[10] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
    tbl[11] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
    tbl[12] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
    tbl[13] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rdy, 1'b0, 32'h0, 1'b0);
      check($sformatf("tbl%0d_req", i), obs_req, tbl[i].req);
      check($sformatf("tbl%0d_addr", i), obs_addr, tbl[i].addr);
      check($sformatf("tbl%0d_valid", i), obs_valid, tbl[i].valid);
      if (tbl[i].valid) begin
        check($sformatf("tbl%0d_pc", i), obs_pc, tbl[i].pc);
        check($sformatf("tbl%0d_instr", i), obs_instr, tbl[i].pc);
      end
    end

    // Redirect with two reads pending: both responses must be dropped.
    do_reset();
    lat_min = 3; lat_max = 3;
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0103, 1'b0);
    check("redir_no_req", obs_req, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      if (hs_fired) begin
        got = 1'b1;
        check("redir_first_pc", obs_pc, 32'h100);
        check("redir_first_instr", obs_instr, 32'h100);
      end
    end
    check("redir_delivered", got, 1'b1);

    // Redirect and consume in the same cycle: the consume is ignored.
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0200, 1'b0);
    check("t4_head_valid", obs_valid, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      if (hs_fired) begin
        got = 1'b1;
        check("t4_first_pc", obs_pc, 32'h200);
      end
    end
    check("t4_delivered", got, 1'b1);

    // Three-cycle memory: outstanding reads never exceed DEPTH, order kept.
    lat_min = 3; lat_max = 3;
    max_out = 0;
    d0 = delivered;
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    check("lat3_max_outstanding_ok", (max_out <= DEPTH), 1'b1);
    check("lat3_progress", (delivered - d0 > 20), 1'b1);

    // Randomized traffic with redirects (some near the 2^32 wrap) and one
    // reset in the middle of operation.
    do_reset();
    salt = $urandom;
    lat_min = 1; lat_max = 4; ready_pct = 70;
    d0 = delivered;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15))) : 32'($urandom);
      if (i == 1500) do_reset();
      step($urandom_range(3) != 0, $urandom_range(31) == 0, rpc, 1'b0);
    end
    check("random_progress", (delivered - d0 > 500), 1'b1);

    // Halt after pc 0x8 is issued: 0, 4, 8 delivered, then halted for good.
    do_reset();
    salt = '0; lat_min = 1; lat_max = 1; ready_pct = 100;
    d0 = delivered;
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("halt_pc8_issued", obs_addr, 32'h8);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("halt_no_req", obs_req, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    check("halt_delivered", delivered - d0, 3);
    check("halt_sticky", o_halted, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 32'h0000_0300, 1'b0);
      check("halt_redir_no_req", obs_req, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      check("halt_redir_ignored_valid", obs_valid, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
